// File: rtl/led_bank_pkg.sv
// -----------------------------------------------------------------------------
// led_bank_pkg
//   Shared definitions for the LED bank and other blocks that reuse its
//   channel mode encoding.
//   - MODE_W : width of a channel mode field
//   - mode_t : OFF / ON / BLINK / PWM channel modes
// -----------------------------------------------------------------------------
package led_bank_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_t;

endpackage : led_bank_pkg

// File: rtl/led_bank_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//   Prescaler producing a registered one-cycle pulse every PRESC_DIV clocks.
//   The first pulse appears PRESC_DIV cycles after reset is released.
//   Parameters:
//     PRESC_DIV : clk cycles per tick (>= 2)
//     PRESC_W   : prescaler counter width, 2^PRESC_W >= PRESC_DIV
//   Ports:
//     clk  : system clock
//     rst  : synchronous reset, active-high
//     tick : one-cycle pulse, registered
// -----------------------------------------------------------------------------
module tick_gen #(
  parameter int PRESC_DIV = 1000,
  parameter int PRESC_W   = 20
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);

  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_d;
  logic               tick_q;
  logic               tick_d;

  // tick is registered from the terminal-count compare, so it is high in the
  // cycle after the prescaler sits at its last value.
  always_comb begin
    tick_d  = (presc_q == PRESC_LAST);
    presc_d = presc_q + PRESC_W'(1);
    if (tick_d) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule : tick_gen

// File: rtl/led_bank.sv
// -----------------------------------------------------------------------------
// led_bank
//   Multi-channel LED driver. Each channel has a mode (OFF / ON / BLINK / PWM)
//   and an 8-bit value written through a single-cycle write port. Channel
//   counters advance on the shared prescaler tick.
//   Parameters:
//     N_CH       : number of LED channels
//     PRESC_DIV  : clk cycles per tick (>= 2)
//     PRESC_W    : prescaler width, 2^PRESC_W >= PRESC_DIV
//     VAL_W      : width of per-channel value and counter
//     ACTIVE_LOW : 1 = LED lit when its output is 0
//   Ports:
//     clk     : system clock
//     rst     : synchronous reset, active-high
//     wr_en   : config write strobe (one cycle)
//     wr_ch   : target channel; indices >= N_CH are ignored
//     wr_mode : 0 OFF, 1 ON, 2 BLINK, 3 PWM
//     wr_val  : BLINK half-period in ticks minus 1, or PWM duty
//     tick    : prescaler pulse, registered
//     led     : LED drive, registered, polarity per ACTIVE_LOW
// -----------------------------------------------------------------------------
module led_bank
  import led_bank_pkg::*;
#(
  parameter int N_CH       = 12,
  parameter int PRESC_DIV  = 1000,
  parameter int PRESC_W    = 20,
  parameter int VAL_W      = 8,
  parameter bit ACTIVE_LOW = 1'b1,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [MODE_W-1:0] wr_mode,
  input  logic [VAL_W-1:0]  wr_val,
  output logic              tick,
  output logic [N_CH-1:0]   led
);

  logic [N_CH-1:0] led_q;
  logic [N_CH-1:0] led_d;

  tick_gen #(
    .PRESC_DIV (PRESC_DIV),
    .PRESC_W   (PRESC_W)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    mode_t              mode_q;
    mode_t              mode_d;
    logic [VAL_W-1:0]   val_q;
    logic [VAL_W-1:0]   val_d;
    logic [VAL_W-1:0]   cnt_q;
    logic [VAL_W-1:0]   cnt_d;
    logic               phase_q;
    logic               phase_d;
    logic               wr_hit;
    logic               lit;

    // Out-of-range indices never equal any generated channel number, so
    // invalid writes fall through without a separate range check.
    assign wr_hit = wr_en && (wr_ch == CH_W'(gi));

    always_comb begin
      mode_d  = mode_q;
      val_d   = val_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (wr_hit) begin
        // A write restarts the channel; a coincident tick is dropped.
        mode_d  = mode_t'(wr_mode);
        val_d   = wr_val;
        cnt_d   = '0;
        phase_d = 1'b0;
      end else if (tick) begin
        case (mode_q)
          MODE_BLINK: begin
            if (cnt_q == val_q) begin
              cnt_d   = '0;
              phase_d = ~phase_q;
            end else begin
              cnt_d = cnt_q + VAL_W'(1);
            end
          end
          MODE_PWM: begin
            cnt_d = cnt_q + VAL_W'(1);
          end
          default: begin
            cnt_d = cnt_q;
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        mode_q  <= MODE_OFF;
        val_q   <= '0;
        cnt_q   <= '0;
        phase_q <= 1'b0;
      end else begin
        mode_q  <= mode_d;
        val_q   <= val_d;
        cnt_q   <= cnt_d;
        phase_q <= phase_d;
      end
    end

    // PWM lights for counter values 0..val-1, so val = 0 is dark and the
    // maximum value is dark for exactly one counter step.
    always_comb begin
      lit = 1'b0;
      case (mode_q)
        MODE_OFF:   lit = 1'b0;
        MODE_ON:    lit = 1'b1;
        MODE_BLINK: lit = phase_q;
        MODE_PWM:   lit = (cnt_q < val_q);
        default:    lit = 1'b0;
      endcase
    end

    assign led_d[gi] = lit ^ ACTIVE_LOW;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= {N_CH{ACTIVE_LOW}};
    end else begin
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule : led_bank

// File: tb/tb_led_bank.sv
// -----------------------------------------------------------------------------
// tb_led_bank
//   Directed bench for led_bank with N_CH = 12, PRESC_DIV = 4, ACTIVE_LOW = 1.
// -----------------------------------------------------------------------------
module tb_led_bank;

  localparam int N_CH = 12;
  localparam int CH_W = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_en = 1'b0;
  logic [CH_W-1:0] wr_ch = '0;
  logic [1:0]      wr_mode = '0;
  logic [7:0]      wr_val = '0;
  logic            tick;
  logic [N_CH-1:0] led;

  int n_cmp = 0;
  int n_bad = 0;

  led_bank #(
    .N_CH       (N_CH),
    .PRESC_DIV  (4),
    .PRESC_W    (3),
    .VAL_W      (8),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_mode (wr_mode),
    .wr_val  (wr_val),
    .tick    (tick),
    .led     (led)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a write for exactly one edge; returns just after that edge.
  task automatic do_write(input int ch, input int mode, input int val);
    wr_en   = 1'b1;
    wr_ch   = CH_W'(ch);
    wr_mode = 2'(mode);
    wr_val  = 8'(val);
    step();
    wr_en = 1'b0;
    $display("write ch=%0d mode=%0d val=%0d at %0t", ch, mode, val, $time);
  endtask

  // Step until tick is seen high at a sample point, bounded.
  task automatic wait_tick();
    bit found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      step();
      if (tick) found = 1'b1;
    end
    if (!found) check_val("tick_timeout", 32'(0), 32'(1));
  endtask

  // Checks tick cadence and idle LEDs for k cycles after reset release.
  task automatic check_after_reset(input int ncyc, input string tag);
    for (int k = 1; k <= ncyc; k++) begin
      step();
      check_val({tag, "_tick"}, 32'(tick), 32'((k % 4) == 0));
      check_val({tag, "_led"}, 32'(led), 32'(12'hFFF));
    end
  endtask

  // Called right after a BLINK val=2 write to ch0. Every 3 applied ticks
  // toggles phase; a tick seen at a sample reaches led two samples later.
  task automatic blink_run(input int ncyc);
    int   applied = 0;
    logic p1 = tick;
    logic p2 = 1'b0;
    logic exp_led;
    for (int k = 1; k <= ncyc; k++) begin
      step();
      applied += int'(p2);
      exp_led = (((applied / 3) % 2) == 1) ? 1'b0 : 1'b1;
      check_val("blink_led0", 32'(led[0]), 32'(exp_led));
      p2 = p1;
      p1 = tick;
    end
    $display("blink run: %0d ticks applied", applied);
  endtask

  initial begin
    int   lit_cnt;
    int   falls;
    logic cur;
    logic prev;
    logic first;

    // Reset state and tick cadence.
    step();
    step();
    check_val("rst_led", 32'(led), 32'(12'hFFF));
    check_val("rst_tick", 32'(tick), 32'(0));
    rst = 1'b0;
    check_after_reset(9, "presc");

    // ON / OFF on channel 3.
    do_write(3, 1, 0);
    check_val("on_not_yet", 32'(led), 32'(12'hFFF));
    step();
    check_val("on_ch3", 32'(led), 32'(12'hFF7));
    do_write(3, 0, 0);
    check_val("off_not_yet", 32'(led), 32'(12'hFF7));
    step();
    check_val("off_ch3", 32'(led), 32'(12'hFFF));

    // BLINK on channel 0, val = 2: toggle every 3 ticks.
    do_write(0, 2, 2);
    blink_run(50);

    // Rewrite channel 0 in a cycle where tick is high: must behave as a fresh start.
    wait_tick();
    do_write(0, 2, 2);
    blink_run(50);

    // PWM on channel 1, duty 64.
    do_write(1, 3, 64);
    step();
    check_val("pwm_lit_cnt0", 32'(led[1]), 32'(0));
    wait_tick();
    step();
    step();
    lit_cnt = 0;
    falls   = 0;
    prev    = 1'b0;
    first   = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      cur = ~led[1];
      if (i == 0) first = cur;
      if (cur) lit_cnt++;
      if (i > 0 && prev && !cur) falls++;
      prev = cur;
      step();
    end
    if (prev && !first) falls++;
    check_val("pwm64_lit_cycles", 32'(lit_cnt), 32'(256));
    check_val("pwm64_segments", 32'(falls), 32'(1));

    do_write(1, 3, 0);
    step();
    lit_cnt = 0;
    for (int i = 0; i < 1030; i++) begin
      if (!led[1]) lit_cnt++;
      step();
    end
    check_val("pwm0_lit_cycles", 32'(lit_cnt), 32'(0));

    // Invalid channel indices must not alias onto real channels.
    do_write(0, 0, 0);
    do_write(1, 1, 0);
    do_write(13, 1, 0);
    do_write(12, 1, 0);
    do_write(15, 1, 0);
    do_write(13, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check_val("invalid_wr", 32'(led), 32'(12'hFFD));
    end

    // Reset mid-PWM, with a coincident write that reset must override.
    do_write(1, 3, 255);
    do_write(2, 1, 0);
    step();
    check_val("pre_rst_led", 32'(led), 32'(12'hFF9));
    rst     = 1'b1;
    wr_en   = 1'b1;
    wr_ch   = 4'd3;
    wr_mode = 2'd1;
    wr_val  = 8'd0;
    step();
    wr_en = 1'b0;
    check_val("mid_rst_led", 32'(led), 32'(12'hFFF));
    check_val("mid_rst_tick", 32'(tick), 32'(0));
    rst = 1'b0;
    check_after_reset(12, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute guard against a hung run.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule : tb_led_bank

// File: doc/led_bank.md
Name: led_bank

Overview:
- Parametrised multi-channel LED driver; successor to the single-output fixed-period blinker.
- Each of N_CH channels has its own mode (off / on / blink / PWM) and an 8-bit period or duty value, written through a simple write port.
- Sits between the board-level top (PLL clock, reset) and the LED pins.
- Output polarity is selectable so negative-logic LEDs are driven directly.

Parameters:
- N_CH, 12, number of LED channels.
- PRESC_DIV, 1000, clk cycles per tick; must be >= 2. At 1 MHz this gives a 1 kHz tick.
- PRESC_W, 20, prescaler counter width; must satisfy 2^PRESC_W >= PRESC_DIV.
- VAL_W, 8, width of the per-channel value and counter.
- ACTIVE_LOW, 1, 1 = LED lit when its output is 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  config write strobe, one cycle.
- wr_ch  in  $clog2(N_CH)  target channel index.
- wr_mode  in  2  mode: 0 OFF, 1 ON, 2 BLINK, 3 PWM.
- wr_val  in  VAL_W  blink half-period in ticks minus 1, or PWM duty.
- tick  out  1  one-cycle prescaler pulse, registered.
- led  out  N_CH  LED drive, registered, polarity per ACTIVE_LOW.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - prescaler = 0, tick = 0;
  - every channel: mode = OFF, val = 0, cnt = 0, phase = 0;
  - led = all inactive (all 1s when ACTIVE_LOW = 1).
  - Reset overrides any write in the same cycle.
  - Reset asserted mid-operation returns all state to these values at the next edge.
- Prescaler:
  - counts 0..PRESC_DIV-1, then wraps to 0;
  - tick = 1 in the cycle after the prescaler equals PRESC_DIV-1;
  - so tick is a one-cycle pulse every PRESC_DIV cycles, and the first tick comes PRESC_DIV cycles after reset release.
- Write:
  - on wr_en with wr_ch < N_CH, the channel's mode and val load at that edge;
  - cnt and phase clear to 0 on the same edge;
  - wr_ch >= N_CH is ignored.
- Per-channel update, on cycles where tick = 1 and no write targets that channel:
  - OFF / ON: cnt is held.
  - BLINK: if cnt == val, then cnt becomes 0 and phase toggles; otherwise cnt + 1. With val = 0, phase toggles every tick.
  - PWM: cnt increments modulo 2^VAL_W (free-running, 8-bit wrap 255 -> 0).
  - A write and a tick on the same channel in the same cycle: the write wins (cnt = 0, phase = 0); the tick is not applied.
- Lit function, evaluated from current state:
  - OFF: 0.
  - ON: 1.
  - BLINK: phase.
  - PWM: (cnt < val). val = 0 is never lit; val = 255 is lit 255 of 256 ticks.
- led[i] = lit_i XOR ACTIVE_LOW, registered.
  - A write at edge t appears on led at edge t+1.
  - A tick-driven change appears one cycle after the state change.
- Arithmetic is unsigned with no saturation; all counters wrap by width.

Decomposition:
- Shared constants file led_bank_defs: MODE_OFF = 2'd0, MODE_ON = 2'd1, MODE_BLINK = 2'd2, MODE_PWM = 2'd3, and the mode width.
- One sub-module, tick_gen (parameters PRESC_DIV, PRESC_W; ports clk, rst, tick), reused by other timing blocks.
- Per-channel logic is a generate loop inside led_bank; it needs no separate module.

Test Plan:
- Reset with N_CH = 12, ACTIVE_LOW = 1 -> led = 12'hFFF and tick = 0; first tick pulse exactly PRESC_DIV = 4 cycles after rst deasserts, then every 4 cycles.
- Write ch 3, ON -> led[3] = 0 one cycle after the write edge; other bits stay 1. Write ch 3, OFF -> led[3] = 1.
- PRESC_DIV = 4, ch 0 BLINK val = 2 -> led[0] toggles every 3 ticks (12 clk); first toggle on the 3rd tick after the write.
- ch 1 PWM val = 64 -> over 256 ticks, led[1] is active for exactly 64 ticks, contiguous, starting at cnt = 0. val = 0 -> never lit.
- Write to ch 0 in the same cycle as tick, while in BLINK -> cnt = 0 and phase = 0 afterwards; no toggle lost or duplicated relative to a fresh start.
- Write wr_ch = 13 (invalid when N_CH = 12) -> no state change. Assert rst mid-PWM -> led = 12'hFFF next cycle, all modes OFF.
